// File: rtl/noc_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter for one NOC router output port.
// A grant is held until FLITS_PER_PKT flits transfer; the priority pointer rotates on packet end.
module noc_pkt_rr_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned FLITS_PER_PKT = 5
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_i,
   input  logic                             xfer_i,
   output logic [NUM_REQ-1:0]               gnt_o,
   output logic [$clog2(NUM_REQ)-1:0]       gnt_idx_o,
   output logic                             busy_o,
   output logic [$clog2(FLITS_PER_PKT)-1:0] flit_cnt_o,
   output logic                             pkt_end_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(FLITS_PER_PKT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLITS_PER_PKT - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [IDX_W-1:0]   idx_d;
   logic [CNT_W-1:0]   cnt_d;

   logic [IDX_W-1:0]   ptr_inc;
   logic [IDX_W-1:0]   arb_base;
   logic [IDX_W:0]     cand;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;

   assign busy_o    = (state_q == BUSY);
   assign pkt_end_o = busy_o & xfer_i & (flit_cnt_o == LAST_CNT);

   // Explicit wrap keeps the increment correct for non-power-of-two NUM_REQ.
   assign ptr_inc  = (gnt_idx_o == LAST_IDX) ? '0 : gnt_idx_o + IDX_W'(1);
   assign arb_base = pkt_end_o ? ptr_inc : ptr_q;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, arb_base} + (IDX_W + 1)'(i);
         if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
            cand = cand - (IDX_W + 1)'(NUM_REQ);
         end
         if (!win_found && req_i[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_o;
      idx_d   = gnt_idx_o;
      cnt_d   = flit_cnt_o;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = BUSY;
               gnt_d   = NUM_REQ'(1) << win_idx;
               idx_d   = win_idx;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (xfer_i) begin
               if (pkt_end_o) begin
                  // Re-arbitrate on the tail flit so back-to-back packets leave no bubble.
                  ptr_d = ptr_inc;
                  cnt_d = '0;
                  if (win_found) begin
                     gnt_d = NUM_REQ'(1) << win_idx;
                     idx_d = win_idx;
                  end else begin
                     state_d = IDLE;
                     gnt_d   = '0;
                     idx_d   = '0;
                  end
               end else begin
                  cnt_d = flit_cnt_o + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gnt_o      <= '0;
         gnt_idx_o  <= '0;
         flit_cnt_o <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_o      <= gnt_d;
         gnt_idx_o  <= idx_d;
         flit_cnt_o <= cnt_d;
      end
   end

endmodule

// File: tb/tb_noc_pkt_rr_arbiter.sv
// Scoreboarded bench for noc_pkt_rr_arbiter: a cycle model predicts grants, queued at arbitration
// time and popped when the DUT presents the new grant.
module tb_noc_pkt_rr_arbiter;

   localparam int N = 4;
   localparam int F = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req_i;
   logic         xfer_i;
   logic [N-1:0] gnt_o;
   logic [1:0]   gnt_idx_o;
   logic         busy_o;
   logic [2:0]   flit_cnt_o;
   logic         pkt_end_o;

   always #5 clk = ~clk;

   noc_pkt_rr_arbiter #(.NUM_REQ(N), .FLITS_PER_PKT(F)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req_i),
      .xfer_i     (xfer_i),
      .gnt_o      (gnt_o),
      .gnt_idx_o  (gnt_idx_o),
      .busy_o     (busy_o),
      .flit_cnt_o (flit_cnt_o),
      .pkt_end_o  (pkt_end_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int m_ptr = 0;
   int m_idx = 0;
   int m_cnt = 0;
   bit m_busy = 1'b0;
   int exp_q[$];

   function automatic int winner(int base, logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[(base + i) % N]) return (base + i) % N;
      end
      return -1;
   endfunction

   function automatic bit exp_end();
      return m_busy && xfer_i && (m_cnt == F - 1);
   endfunction

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] one;
      one = 1;
      return m_busy ? (one << m_idx) : '0;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_idx = 0; m_cnt = 0; m_busy = 1'b0;
      exp_q.delete();
   endtask

   // Advances the reference model using the inputs currently driven, then crosses the clock edge.
   task automatic tick(output bit granted);
      int w;
      granted = 1'b0;
      w = -1;
      if (!m_busy) begin
         w = winner(m_ptr, req_i);
         if (w >= 0) granted = 1'b1;
      end else if (xfer_i) begin
         if (m_cnt < F - 1) begin
            m_cnt++;
         end else begin
            m_ptr = (m_idx + 1) % N;
            m_cnt = 0;
            w = winner(m_ptr, req_i);
            if (w >= 0) granted = 1'b1;
            else begin m_busy = 1'b0; m_idx = 0; end
         end
      end
      if (granted) begin
         m_busy = 1'b1; m_idx = w; m_cnt = 0;
         exp_q.push_back(w);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_i = '0; xfer_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         xfer_i = c[0];
         @(negedge clk);
         n_cmp++;
         if (gnt_o !== '0 || busy_o !== 1'b0 || flit_cnt_o !== '0 || gnt_idx_o !== '0 || pkt_end_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got gnt=%b idx=%0d busy=%b cnt=%0d end=%b want all zero",
                     gnt_o, gnt_idx_o, busy_o, flit_cnt_o, pkt_end_o);
         end
      end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      // Idle with xfer_i high must not move the counter.
      for (int c = 0; c < 3; c++) begin
         bit g; int e;
         xfer_i = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (pkt_end_o !== exp_end()) begin
            n_bad++; $display("FAIL idle_pkt_end: got %b want %b", pkt_end_o, exp_end());
         end
         tick(g);
         n_cmp++;
         if (busy_o !== m_busy || flit_cnt_o !== m_cnt[2:0] || gnt_o !== exp_gnt()) begin
            n_bad++;
            $display("FAIL idle_state: got busy=%b cnt=%0d gnt=%b want busy=%b cnt=%0d gnt=%b",
                     busy_o, flit_cnt_o, gnt_o, m_busy, m_cnt, exp_gnt());
         end
         if (g) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt_idx_o !== e[1:0]) begin
               n_bad++; $display("FAIL idle_grant: got idx=%0d want %0d", gnt_idx_o, e);
            end
         end
      end
   endtask

   task automatic test_single();
      logic [N-1:0] rq [7] = '{4'b0100, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
      bit           xf [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 7; c++) begin
         bit g; int e;
         req_i = rq[c]; xfer_i = xf[c];
         @(negedge clk);
         n_cmp++;
         if (pkt_end_o !== exp_end()) begin
            n_bad++; $display("FAIL single_pkt_end: cycle %0d got %b want %b", c, pkt_end_o, exp_end());
         end
         tick(g);
         n_cmp++;
         if (busy_o !== m_busy || flit_cnt_o !== m_cnt[2:0] || gnt_o !== exp_gnt() || gnt_idx_o !== m_idx[1:0]) begin
            n_bad++;
            $display("FAIL single_state: cycle %0d got busy=%b cnt=%0d gnt=%b idx=%0d want busy=%b cnt=%0d gnt=%b idx=%0d",
                     c, busy_o, flit_cnt_o, gnt_o, gnt_idx_o, m_busy, m_cnt, exp_gnt(), m_idx);
         end
         if (g) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt_idx_o !== e[1:0] || e != 2) begin
               n_bad++; $display("FAIL single_grant: got idx=%0d want %0d", gnt_idx_o, e);
            end
         end
      end
   endtask

   task automatic test_wrap();
      for (int c = 0; c < 17; c++) begin
         bit g; int e;
         req_i  = (c >= 15) ? 4'b0000 : 4'b1001;
         xfer_i = (c != 0 && c != 16);
         @(negedge clk);
         n_cmp++;
         if (pkt_end_o !== exp_end()) begin
            n_bad++; $display("FAIL wrap_pkt_end: cycle %0d got %b want %b", c, pkt_end_o, exp_end());
         end
         tick(g);
         n_cmp++;
         if (busy_o !== m_busy || flit_cnt_o !== m_cnt[2:0] || gnt_o !== exp_gnt()) begin
            n_bad++;
            $display("FAIL wrap_state: cycle %0d got busy=%b cnt=%0d gnt=%b want busy=%b cnt=%0d gnt=%b",
                     c, busy_o, flit_cnt_o, gnt_o, m_busy, m_cnt, exp_gnt());
         end
         if (g) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt_idx_o !== e[1:0]) begin
               n_bad++; $display("FAIL wrap_grant: cycle %0d got idx=%0d want %0d", c, gnt_idx_o, e);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int pkts = 0;
      for (int c = 0; c < 27; c++) begin
         bit g; int e;
         req_i  = (c >= 25) ? 4'b0000 : 4'b1111;
         xfer_i = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (pkt_end_o !== exp_end()) begin
            n_bad++; $display("FAIL b2b_pkt_end: cycle %0d got %b want %b", c, pkt_end_o, exp_end());
         end
         tick(g);
         n_cmp++;
         if (busy_o !== m_busy || flit_cnt_o !== m_cnt[2:0] || gnt_o !== exp_gnt()) begin
            n_bad++;
            $display("FAIL b2b_state: cycle %0d got busy=%b cnt=%0d gnt=%b want busy=%b cnt=%0d gnt=%b",
                     c, busy_o, flit_cnt_o, gnt_o, m_busy, m_cnt, exp_gnt());
         end
         if (g) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt_idx_o !== e[1:0] || e != (pkts % N)) begin
               n_bad++;
               $display("FAIL b2b_grant: packet %0d got idx=%0d want %0d", pkts, gnt_idx_o, pkts % N);
            end
            pkts++;
         end
      end
      n_cmp++;
      if (pkts != 5) begin
         n_bad++; $display("FAIL b2b_count: got %0d packets want 5", pkts);
      end
   endtask

   task automatic test_owner_drop();
      bit xf [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int c = 0; c < 11; c++) begin
         bit g; int e;
         req_i  = (c == 0 || m_cnt < 2) ? 4'b0010 : 4'b0000;
         if (c == 10) req_i = '0;
         xfer_i = (c < 10) ? xf[c] : 1'b0;
         @(negedge clk);
         n_cmp++;
         if (pkt_end_o !== exp_end()) begin
            n_bad++; $display("FAIL drop_pkt_end: cycle %0d got %b want %b", c, pkt_end_o, exp_end());
         end
         tick(g);
         n_cmp++;
         if (busy_o !== m_busy || flit_cnt_o !== m_cnt[2:0] || gnt_o !== exp_gnt()) begin
            n_bad++;
            $display("FAIL drop_state: cycle %0d got busy=%b cnt=%0d gnt=%b want busy=%b cnt=%0d gnt=%b",
                     c, busy_o, flit_cnt_o, gnt_o, m_busy, m_cnt, exp_gnt());
         end
         if (g) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt_idx_o !== e[1:0] || e != 1) begin
               n_bad++; $display("FAIL drop_grant: got idx=%0d want %0d", gnt_idx_o, e);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      bit g; int e;
      req_i = 4'b1010; xfer_i = 1'b0;
      for (int c = 0; c < 12 && !(m_busy && m_cnt == 3); c++) begin
         @(negedge clk);
         tick(g);
         if (g) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt_idx_o !== e[1:0]) begin
               n_bad++; $display("FAIL mreset_grant: got idx=%0d want %0d", gnt_idx_o, e);
            end
         end
         xfer_i = 1'b1;
      end
      n_cmp++;
      if (flit_cnt_o !== 3'd3 || busy_o !== 1'b1) begin
         n_bad++; $display("FAIL mreset_setup: got cnt=%0d busy=%b want 3 1", flit_cnt_o, busy_o);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (gnt_o !== '0 || flit_cnt_o !== '0 || busy_o !== 1'b0 || gnt_idx_o !== '0 || pkt_end_o !== 1'b0) begin
         n_bad++;
         $display("FAIL mreset_async: got gnt=%b cnt=%0d busy=%b idx=%0d end=%b want all zero",
                  gnt_o, flit_cnt_o, busy_o, gnt_idx_o, pkt_end_o);
      end
      @(posedge clk); #1;
      reset = 1'b1; xfer_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         req_i = (c == 0) ? 4'b1010 : 4'b0010;
         @(negedge clk);
         tick(g);
         n_cmp++;
         if (busy_o !== m_busy || flit_cnt_o !== m_cnt[2:0] || gnt_o !== exp_gnt()) begin
            n_bad++;
            $display("FAIL mreset_state: got busy=%b cnt=%0d gnt=%b want busy=%b cnt=%0d gnt=%b",
                     busy_o, flit_cnt_o, gnt_o, m_busy, m_cnt, exp_gnt());
         end
         if (g) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt_idx_o !== e[1:0] || e != 1) begin
               n_bad++; $display("FAIL mreset_regrant: got idx=%0d want %0d", gnt_idx_o, e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_back_to_back();
      test_owner_drop();
      test_mid_reset();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
